// File: rtl/sap3_pkg.sv
// Shared SAP-3 definitions: command op codes, register pair codes, register-file
// ext codes, sequencer FSM states and operand legality helpers.
package sap3_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MOV8  = 3'b001,
        OP_MOV16 = 3'b010,
        OP_XCHG  = 3'b011,
        OP_INX   = 3'b100,
        OP_DCX   = 3'b101,
        OP_PUSH  = 3'b110,
        OP_POP   = 3'b111
    } op_e;

    localparam logic [3:0] PAIR_BC = 4'd0;
    localparam logic [3:0] PAIR_DE = 4'd2;
    localparam logic [3:0] PAIR_HL = 4'd4;
    localparam logic [3:0] PAIR_WZ = 4'd6;
    localparam logic [3:0] PAIR_PC = 4'd8;
    localparam logic [3:0] PAIR_SP = 4'd10;

    localparam logic [3:0] BYTE_MAX = 4'd11;

    // EXT_ADD2 is decoded by the register file but never issued by the sequencer.
    typedef enum logic [1:0] {
        EXT_NONE = 2'b00,
        EXT_INC  = 2'b01,
        EXT_DEC  = 2'b10,
        EXT_ADD2 = 2'b11
    } ext_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_X1   = 2'b01,
        ST_X2   = 2'b10,
        ST_X3   = 2'b11
    } state_e;

    function automatic logic is_byte(input logic [3:0] code);
        return code <= BYTE_MAX;
    endfunction

    function automatic logic is_pair(input logic [3:0] code);
        return (code <= PAIR_SP) && !code[0];
    endfunction

    function automatic logic cmd_legal(input op_e op, input logic [3:0] dst,
                                       input logic [3:0] src);
        logic ok;
        ok = 1'b1;
        case (op)
            OP_NOP:         ok = 1'b1;
            OP_MOV8:        ok = is_byte(dst) && is_byte(src);
            OP_MOV16:       ok = is_pair(dst) && is_pair(src);
            OP_XCHG:        ok = is_pair(dst) && is_pair(src) &&
                                 (dst != PAIR_WZ) && (src != PAIR_WZ);
            OP_INX, OP_DCX: ok = is_pair(dst);
            OP_PUSH:        ok = is_pair(src);
            OP_POP:         ok = is_pair(dst);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/reg_seq.sv
// Register-transfer sequencer: expands one register-level command into 1-3 cycles
// of register-file port activity plus byte memory accesses for PUSH/POP.
module reg_seq
    import sap3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_dst,
    input  logic [3:0]  cmd_src,
    output logic        done,
    output logic        cmd_err,
    output logic [4:0]  rf_rd_sel,
    output logic [4:0]  rf_wr_sel,
    output logic [1:0]  rf_ext,
    output logic        rf_we,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [3:0]  dst_q, dst_d;
    logic [3:0]  src_q, src_d;
    logic [15:0] tmp_q, tmp_d;
    logic        legal;

    localparam logic [4:0] SEL_WZ = {1'b1, PAIR_WZ};
    localparam logic [4:0] SEL_SP = {1'b1, PAIR_SP};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            dst_q   <= 4'd0;
            src_q   <= 4'd0;
            tmp_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            tmp_q   <= tmp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        src_d     = src_q;
        tmp_d     = tmp_q;
        cmd_ready = (state_q == ST_IDLE);
        done      = 1'b0;
        cmd_err   = 1'b0;
        rf_rd_sel = 5'd0;
        rf_wr_sel = 5'd0;
        rf_ext    = EXT_NONE;
        rf_we     = 1'b0;
        rf_wdata  = 16'h0000;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        legal     = cmd_legal(op_q, dst_q, src_q);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    dst_d   = cmd_dst;
                    src_d   = cmd_src;
                    state_d = ST_X1;
                end
            end

            ST_X1: begin
                state_d = ST_IDLE;
                if (!legal) begin
                    cmd_err = 1'b1;
                end else begin
                    case (op_q)
                        OP_NOP: done = 1'b1;
                        OP_MOV8, OP_MOV16: begin
                            rf_rd_sel = {op_q == OP_MOV16, src_q};
                            rf_wr_sel = {op_q == OP_MOV16, dst_q};
                            rf_we     = 1'b1;
                            rf_wdata  = rf_rdata;
                            done      = 1'b1;
                        end
                        OP_INX, OP_DCX: begin
                            rf_wr_sel = {1'b1, dst_q};
                            rf_ext    = (op_q == OP_INX) ? EXT_INC : EXT_DEC;
                            done      = 1'b1;
                        end
                        // WZ is a scratch pair for the three-way swap.
                        OP_XCHG: begin
                            rf_rd_sel = {1'b1, dst_q};
                            rf_wr_sel = SEL_WZ;
                            rf_we     = 1'b1;
                            rf_wdata  = rf_rdata;
                            state_d   = ST_X2;
                        end
                        OP_PUSH: begin
                            rf_rd_sel = {1'b1, src_q};
                            tmp_d     = rf_rdata;
                            rf_wr_sel = SEL_SP;
                            rf_ext    = EXT_DEC;
                            state_d   = ST_X2;
                        end
                        OP_POP: begin
                            rf_rd_sel = SEL_SP;
                            mem_addr  = rf_rdata;
                            mem_re    = 1'b1;
                            rf_wr_sel = SEL_SP;
                            rf_ext    = EXT_INC;
                            state_d   = ST_X2;
                        end
                        default: done = 1'b1;
                    endcase
                end
            end

            ST_X2: begin
                state_d = ST_X3;
                case (op_q)
                    OP_XCHG: begin
                        rf_rd_sel = {1'b1, src_q};
                        rf_wr_sel = {1'b1, dst_q};
                        rf_we     = 1'b1;
                        rf_wdata  = rf_rdata;
                    end
                    OP_PUSH: begin
                        rf_rd_sel = SEL_SP;
                        mem_addr  = rf_rdata;
                        mem_wdata = tmp_q[15:8];
                        mem_we    = 1'b1;
                        rf_wr_sel = SEL_SP;
                        rf_ext    = EXT_DEC;
                    end
                    OP_POP: begin
                        rf_rd_sel  = SEL_SP;
                        mem_addr   = rf_rdata;
                        mem_re     = 1'b1;
                        tmp_d[7:0] = mem_rdata;
                        rf_wr_sel  = SEL_SP;
                        rf_ext     = EXT_INC;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            ST_X3: begin
                state_d = ST_IDLE;
                done    = 1'b1;
                case (op_q)
                    OP_XCHG: begin
                        rf_rd_sel = SEL_WZ;
                        rf_wr_sel = {1'b1, src_q};
                        rf_we     = 1'b1;
                        rf_wdata  = rf_rdata;
                    end
                    OP_PUSH: begin
                        rf_rd_sel = SEL_SP;
                        mem_addr  = rf_rdata;
                        mem_wdata = tmp_q[7:0];
                        mem_we    = 1'b1;
                    end
                    // Final write to the destination wins even when it is SP itself.
                    OP_POP: begin
                        rf_wr_sel = {1'b1, dst_q};
                        rf_we     = 1'b1;
                        rf_wdata  = {mem_rdata, tmp_q[7:0]};
                    end
                    default: done = 1'b0;
                endcase
            end

            default: state_d = ST_IDLE;
        endcase

        // Reset aborts in the same cycle: no strobe may escape while rst is high.
        if (rst) begin
            done      = 1'b0;
            cmd_err   = 1'b0;
            rf_rd_sel = 5'd0;
            rf_wr_sel = 5'd0;
            rf_ext    = EXT_NONE;
            rf_we     = 1'b0;
            rf_wdata  = 16'h0000;
            mem_addr  = 16'h0000;
            mem_wdata = 8'h00;
            mem_we    = 1'b0;
            mem_re    = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_seq.sv
// Directed bench for reg_seq with a behavioural register file and byte memory
// attached to the sequencer ports.
module tb_reg_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_dst;
    logic [3:0]  cmd_src;
    logic        done;
    logic        cmd_err;
    logic [4:0]  rf_rd_sel;
    logic [4:0]  rf_wr_sel;
    logic [1:0]  rf_ext;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    reg_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src   (cmd_src),
        .done      (done),
        .cmd_err   (cmd_err),
        .rf_rd_sel (rf_rd_sel),
        .rf_wr_sel (rf_wr_sel),
        .rf_ext    (rf_ext),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- register file / memory environment ----------------
    logic [15:0] rf [0:7];
    logic [7:0]  mem [0:65535];
    int          mem_wr_cnt = 0;
    logic        pre_rf_we = 1'b0;
    logic [2:0]  pre_rf_idx = 3'd0;
    logic [15:0] pre_rf_val = 16'h0;
    logic        pre_mem_we = 1'b0;
    logic [15:0] pre_mem_addr = 16'h0;
    logic [7:0]  pre_mem_val = 8'h0;
    logic [2:0]  rd_p, wr_p;

    assign rd_p = rf_rd_sel[3:1];
    assign wr_p = rf_wr_sel[3:1];

    always_comb begin
        if (rf_rd_sel[4])      rf_rdata = rf[rd_p];
        else if (rf_rd_sel[0]) rf_rdata = {8'h00, rf[rd_p][7:0]};
        else                   rf_rdata = {8'h00, rf[rd_p][15:8]};
    end

    always @(posedge clk) begin
        if (pre_rf_we) rf[pre_rf_idx] <= pre_rf_val;
        else if (rf_we) begin
            if (rf_wr_sel[4])      rf[wr_p] <= rf_wdata;
            else if (rf_wr_sel[0]) rf[wr_p][7:0] <= rf_wdata[7:0];
            else                   rf[wr_p][15:8] <= rf_wdata[7:0];
        end
        else if (rf_ext == 2'b01) rf[wr_p] <= rf[wr_p] + 16'd1;
        else if (rf_ext == 2'b10) rf[wr_p] <= rf[wr_p] - 16'd1;
        else if (rf_ext == 2'b11) rf[wr_p] <= rf[wr_p] + 16'd2;

        if (pre_mem_we) mem[pre_mem_addr] <= pre_mem_val;
        else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            mem_wr_cnt    <= mem_wr_cnt + 1;
        end
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks (start and end just after a negedge) ----------------
    task automatic set_pair(input logic [2:0] idx, input logic [15:0] val);
        pre_rf_we = 1'b1; pre_rf_idx = idx; pre_rf_val = val;
        @(posedge clk);
        @(negedge clk);
        pre_rf_we = 1'b0;
    endtask

    task automatic set_mem(input logic [15:0] addr, input logic [7:0] val);
        pre_mem_we = 1'b1; pre_mem_addr = addr; pre_mem_val = val;
        @(posedge clk);
        @(negedge clk);
        pre_mem_we = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] src,
                           output int lat, output logic err, output logic fin_done,
                           output logic ready_x1, output logic ready_after,
                           output logic pulse_after);
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        ready_x1  = cmd_ready;
        lat = 1;
        while (!(done || cmd_err) && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        err      = cmd_err;
        fin_done = done;
        @(negedge clk);
        ready_after = cmd_ready;
        pulse_after = done | cmd_err;
    endtask

    function automatic logic [127:0] rf_snap();
        return {rf[0], rf[1], rf[2], rf[3], rf[4], rf[5], rf[6], rf[7]};
    endfunction

    // ---------------- stimulus ----------------
    int          lat;
    logic        err, fin_done, ready_x1, ready_after, pulse_after;
    logic [127:0] snap;
    int          wc;

    logic [2:0] bad_op  [4] = '{3'd2, 3'd3, 3'd1, 3'd6};
    logic [3:0] bad_dst [4] = '{4'd0, 4'd6, 4'd12, 4'd0};
    logic [3:0] bad_src [4] = '{4'd3, 4'd0, 4'd0, 4'd11};

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_dst = 4'd0; cmd_src = 4'd0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_done_err", {30'b0, done, cmd_err}, 32'd0);
        check("rst_rf_ctl", {20'b0, rf_rd_sel, rf_wr_sel, rf_ext}, 32'd0);
        check("rst_rf_wr", {15'b0, rf_we, rf_wdata}, 32'd0);
        check("rst_mem", {6'b0, mem_addr, mem_wdata, mem_we, mem_re}, 32'd0);

        // MOV8 C <- B
        set_pair(3'd0, 16'h1200);
        run_cmd(3'd1, 4'd1, 4'd0, lat, err, fin_done, ready_x1, ready_after, pulse_after);
        check("mov8_bc", {16'b0, rf[0]}, 32'h1212);
        check("mov8_lat", lat, 32'd1);
        check("mov8_done", {30'b0, fin_done, err}, 32'd2);
        check("mov8_busy", {31'b0, ready_x1}, 32'd0);
        check("mov8_ready_after", {31'b0, ready_after}, 32'd1);
        check("mov8_pulse_once", {31'b0, pulse_after}, 32'd0);

        // XCHG HL, DE
        set_pair(3'd2, 16'hABCD);
        set_pair(3'd1, 16'hABCD);
        set_pair(3'd2, 16'h1234);
        run_cmd(3'd3, 4'd4, 4'd2, lat, err, fin_done, ready_x1, ready_after, pulse_after);
        check("xchg_hl", {16'b0, rf[2]}, 32'hABCD);
        check("xchg_de", {16'b0, rf[1]}, 32'h1234);
        check("xchg_wz", {16'b0, rf[3]}, 32'h1234);
        check("xchg_lat", lat, 32'd3);
        check("xchg_ready_after", {31'b0, ready_after}, 32'd1);

        // MOV16 BC <- HL
        run_cmd(3'd2, 4'd0, 4'd4, lat, err, fin_done, ready_x1, ready_after, pulse_after);
        check("mov16_bc", {16'b0, rf[0]}, 32'hABCD);
        check("mov16_lat", lat, 32'd1);

        // PUSH BC with SP wrapping below zero
        set_pair(3'd5, 16'h0000);
        set_pair(3'd0, 16'hBEEF);
        run_cmd(3'd6, 4'd0, 4'd0, lat, err, fin_done, ready_x1, ready_after, pulse_after);
        check("push_hi", {24'b0, mem[16'hFFFF]}, 32'hBE);
        check("push_lo", {24'b0, mem[16'hFFFE]}, 32'hEF);
        check("push_sp", {16'b0, rf[5]}, 32'hFFFE);
        check("push_lat", lat, 32'd3);

        // POP DE
        set_pair(3'd1, 16'h0000);
        run_cmd(3'd7, 4'd2, 4'd0, lat, err, fin_done, ready_x1, ready_after, pulse_after);
        check("pop_de", {16'b0, rf[1]}, 32'hBEEF);
        check("pop_sp", {16'b0, rf[5]}, 32'h0000);
        check("pop_lat", lat, 32'd3);

        // INX / DCX wrap on SP
        set_pair(3'd5, 16'hFFFF);
        run_cmd(3'd4, 4'd10, 4'd0, lat, err, fin_done, ready_x1, ready_after, pulse_after);
        check("inx_wrap", {16'b0, rf[5]}, 32'h0000);
        check("inx_lat", lat, 32'd1);
        run_cmd(3'd5, 4'd10, 4'd0, lat, err, fin_done, ready_x1, ready_after, pulse_after);
        check("dcx_wrap", {16'b0, rf[5]}, 32'hFFFF);

        // POP into SP: final write overrides the increments
        set_pair(3'd5, 16'h1000);
        set_mem(16'h1000, 8'h34);
        set_mem(16'h1001, 8'h12);
        run_cmd(3'd7, 4'd10, 4'd0, lat, err, fin_done, ready_x1, ready_after, pulse_after);
        check("pop_sp_dst", {16'b0, rf[5]}, 32'h1234);

        // Illegal commands: cmd_err only, no side effects
        for (int i = 0; i < 4; i++) begin
            snap = rf_snap();
            wc   = mem_wr_cnt;
            run_cmd(bad_op[i], bad_dst[i], bad_src[i], lat, err, fin_done, ready_x1,
                    ready_after, pulse_after);
            check($sformatf("illegal%0d_err_done", i), {30'b0, err, fin_done}, 32'd2);
            check($sformatf("illegal%0d_lat", i), lat, 32'd1);
            check($sformatf("illegal%0d_rf", i), {31'b0, rf_snap() == snap}, 32'd1);
            check($sformatf("illegal%0d_mem", i), mem_wr_cnt, wc);
            check($sformatf("illegal%0d_ready", i), {31'b0, ready_after}, 32'd1);
        end

        // Reset during PUSH X2
        set_pair(3'd5, 16'h0005);
        set_pair(3'd0, 16'hBEEF);
        wc = mem_wr_cnt;
        cmd_op = 3'd6; cmd_dst = 4'd0; cmd_src = 4'd0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstx2_mem_we", {31'b0, mem_we}, 32'd0);
        check("rstx2_outs", {8'b0, rf_rd_sel, rf_wr_sel, rf_ext, rf_we, done, cmd_err,
                             mem_wdata}, 32'd0);
        check("rstx2_addr", {14'b0, mem_addr, mem_re, rf_wdata[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstx2_ready", {31'b0, cmd_ready}, 32'd1);
        check("rstx2_sp", {16'b0, rf[5]}, 32'h0004);
        check("rstx2_idle_outs", {20'b0, rf_rd_sel, rf_wr_sel, rf_ext}, 32'd0);
        @(negedge clk);
        check("rstx2_no_write", mem_wr_cnt, wc);
        check("rstx2_still_idle", {30'b0, mem_we, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule

// File: doc/reg_seq.md
# reg_seq

Register-transfer sequencer for the SAP-3 register file. It accepts one register-level command at a time from the control unit over a valid/ready handshake. It expands each command into 1–3 cycles of register-file port activity (read select, write select, ext inc/dec, write enable) plus byte-wide memory accesses for PUSH/POP. It sits between the instruction decoder and the register file and is the only driver of the register-file control ports.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE
- cmd_op  in  3  000 NOP, 001 MOV8, 010 MOV16, 011 XCHG, 100 INX, 101 DCX, 110 PUSH, 111 POP
- cmd_dst  in  4  destination register/pair code
- cmd_src  in  4  source register/pair code
- done  out  1  one-cycle pulse on the final execute cycle of an accepted command
- cmd_err  out  1  one-cycle pulse instead of `done` for an illegal command; no side effects
- rf_rd_sel  out  5  to register-file read select; bit 4 = 16-bit
- rf_wr_sel  out  5  to register-file write select; bit 4 = 16-bit
- rf_ext  out  2  00 none, 01 INC, 10 DEC; 11 is never driven
- rf_we  out  1  register-file write enable
- rf_wdata  out  16  register-file write data
- rf_rdata  in  16  register-file read data, combinational from rf_rd_sel
- mem_addr  out  16  memory byte address
- mem_wdata  out  8  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe; mem_rdata is valid the following cycle
- mem_rdata  in  8  memory read data

## Operation
- Byte codes are 0–11: even = high byte, odd = low byte.
- Pair codes are BC=0, DE=2, HL=4, WZ=6, PC=8, SP=10.
- Legality:
  - MOV8 needs dst and src ≤ 11.
  - MOV16, INX and DCX need even codes ≤ 10 for every pair operand used.
  - XCHG needs legal pairs, with neither operand equal to WZ.
  - PUSH needs a legal src; POP needs a legal dst.
  - A violation pulses `cmd_err` in the cycle after acceptance.
- States: IDLE, X1, X2, X3.
  - Acceptance (cmd_valid & cmd_ready) latches op/dst/src and moves the FSM to X1.
  - After the last X cycle the FSM returns to IDLE.
- Per-op sequence, per cycle:
  - NOP: X1 done.
  - MOV8: X1 rd {0,src}, wr {0,dst}, we, wdata = rf_rdata; done.
  - MOV16: X1 as MOV8 with bit 4 set on both selects.
  - INX/DCX: X1 wr {1,dst}, ext INC/DEC; done. 16-bit wrap: FFFF+1 = 0000, 0000−1 = FFFF.
  - XCHG (WZ used as temp):
    - X1 rd dst, wr WZ.
    - X2 rd src, wr dst.
    - X3 rd WZ, wr src; done.
  - PUSH (SP ends at SP−2, high byte at SP−1):
    - X1 rd src, tmp ← rf_rdata; wr SP, ext DEC.
    - X2 rd SP, mem_addr = rf_rdata, mem_wdata = tmp[15:8], mem_we; ext DEC SP.
    - X3 rd SP, mem_addr = rf_rdata, mem_wdata = tmp[7:0], mem_we; done.
  - POP (low byte first, SP ends at SP+2):
    - X1 rd SP, mem_addr = rf_rdata, mem_re; ext INC SP.
    - X2 rd SP, mem_addr = rf_rdata, mem_re; tmp[7:0] ← mem_rdata; ext INC SP.
    - X3 wr {1,dst}, we, wdata = {mem_rdata, tmp[7:0]}; done.
- Bytes at SP−1 and SP−2 wrap modulo 2^16.
- POP dst = SP is legal; the final write overrides the increments.
- In IDLE and in any cycle/field not listed above, all rf_*/mem_* outputs are 0.

## Timing
- Reset: state IDLE, tmp = 0; done = cmd_err = 0, all rf_*/mem_* outputs = 0, cmd_ready = 1.
- Reset mid-operation aborts immediately. No further strobes follow; register-file and memory side effects already committed remain.
- Latency from the acceptance cycle to `done`: 1 cycle for NOP/MOV/INX/DCX/illegal, 3 cycles for XCHG/PUSH/POP.
- cmd_ready is low from the cycle after acceptance through the `done`/`cmd_err` cycle. It is high again the next cycle, so commands can be issued back-to-back every 2 or 4 cycles.
- cmd_* inputs are ignored while cmd_ready = 0.
- Register-file writes and ext updates commit at the edge ending the cycle that drives them. Reads in the next X cycle see the updated value.

## Structure
- Shared package `sap3_pkg` holds:
  - op codes;
  - pair codes;
  - ext codes (the register file decodes 11 as +2; this block never drives it);
  - the FSM state enum.
- Single flat module with no sub-modules.

## Test plan
- Preload B=12h, C=00h; MOV8 dst=C src=B → C=12h, done one cycle after acceptance, cmd_ready high the following cycle.
- HL=1234h, DE=ABCDh; XCHG dst=HL src=DE → HL=ABCDh, DE=1234h, WZ=1234h, done on the 3rd execute cycle.
- SP=0000h, BC=BEEFh; PUSH BC → mem[FFFF]=BEh, mem[FFFE]=EFh, SP=FFFEh.
- SP=FFFEh with the memory above; POP DE → DE=BEEFh, SP=0000h. Then INX on SP=FFFFh → 0000h; DCX on 0000h → FFFFh.
- Illegal commands (MOV16 src=3, XCHG with WZ, MOV8 dst=12) → cmd_err pulse only; registers and memory unchanged.
- PUSH with rst asserted in X2 → SP decremented once, no mem_we in the rst cycle or after, all outputs 0, cmd_ready = 1 after reset.
